// File: rtl/mvm_layer_ctrl.sv
// Control sequencer for one fully connected layer: load x, run P-wide MAC passes, emit P results per pass.
// Latency: N + (M/P)*(N+1+P) cycles per vector at full rate; output strobes are combinational from state.
// Backpressure: input_ready only in LOAD; EMIT holds out_sel until output_ready. Optional MVM_LAYER_CTRL_PERF_EN adds counters.
module mvm_layer_ctrl #(
    parameter int M = 8,
    parameter int N = 4,
    parameter int P = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       input_valid,
    output logic                       input_ready,
    output logic                       x_wr_en,
    output logic [$clog2(N)-1:0]       x_addr,
    output logic [$clog2(M/P*N)-1:0]   w_addr,
    output logic                       mac_clear,
    output logic                       mac_en,
    output logic [$clog2(P)-1:0]       out_sel,
    output logic                       output_valid,
    input  logic                       output_ready
`ifdef MVM_LAYER_CTRL_PERF_EN
    ,
    output logic [31:0]                busy_cycles,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int NPASS = M / P;
    localparam int XW    = $clog2(N);
    localparam int WW    = $clog2(M / P * N);
    localparam int SW    = $clog2(P);
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;

    localparam logic [XW-1:0] IDX_LAST  = XW'(N - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(NPASS - 1);
    localparam logic [SW-1:0] SEL_LAST  = SW'(P - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  ld_q, ld_d;
    logic [XW-1:0]  k_q, k_d;
    logic [PW-1:0]  pass_q, pass_d;
    logic [SW-1:0]  e_q, e_d;

    // State and counter registers; reset abandons any phase and restarts loading at ld=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            ld_q    <= '0;
            k_q     <= '0;
            pass_q  <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            k_q     <= k_d;
            pass_q  <= pass_d;
            e_q     <= e_d;
        end
    end

    // Next-state and strobe decode; every output is forced low while reset is asserted.
    // mac_en trails the read issue by one cycle to match the 1-cycle memory latency,
    // so it is low on the k==0 clear cycle and high on the DRAIN cycle.
    always_comb begin
        state_d      = state_q;
        ld_d         = ld_q;
        k_d          = k_q;
        pass_d       = pass_q;
        e_d          = e_q;
        input_ready  = 1'b0;
        x_wr_en      = 1'b0;
        x_addr       = '0;
        w_addr       = '0;
        mac_clear    = 1'b0;
        mac_en       = 1'b0;
        out_sel      = '0;
        output_valid = 1'b0;
        if (!reset) begin
            case (state_q)
                S_LOAD: begin
                    input_ready = 1'b1;
                    x_wr_en     = input_valid;
                    x_addr      = ld_q;
                    if (input_valid) begin
                        if (ld_q == IDX_LAST) begin
                            ld_d    = '0;
                            k_d     = '0;
                            state_d = S_COMPUTE;
                        end else begin
                            ld_d = ld_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    x_addr    = k_q;
                    w_addr    = WW'(pass_q) * WW'(N) + WW'(k_q);
                    mac_clear = (k_q == '0);
                    mac_en    = (k_q != '0);
                    if (k_q == IDX_LAST) begin
                        k_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    mac_en  = 1'b1;
                    e_d     = '0;
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    output_valid = 1'b1;
                    out_sel      = e_q;
                    if (output_ready) begin
                        if (e_q == SEL_LAST) begin
                            e_d = '0;
                            if (pass_q == PASS_LAST) begin
                                pass_d  = '0;
                                state_d = S_LOAD;
                            end else begin
                                pass_d  = pass_q + 1'b1;
                                state_d = S_COMPUTE;
                            end
                        end else begin
                            e_d = e_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

`ifdef MVM_LAYER_CTRL_PERF_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] stall_q, stall_d;

    // Saturating activity counters: busy for any non-LOAD cycle, stall for EMIT held by the sink.
    always_comb begin
        busy_d  = busy_q;
        stall_d = stall_q;
        if (state_q != S_LOAD && busy_q != 32'hFFFF_FFFF) begin
            busy_d = busy_q + 32'd1;
        end
        if (state_q == S_EMIT && !output_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign busy_cycles  = reset ? 32'd0 : busy_q;
    assign stall_cycles = reset ? 32'd0 : stall_q;
`endif

endmodule

// File: tb/tb_mvm_layer_ctrl.sv
// Bench for mvm_layer_ctrl: directed table and corner sequences on the default build,
// plus a randomized valid/ready run on an M=16, N=8, P=4 instance checked through queues.
module tb_mvm_layer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       reset, iv, ordy;
    logic       ir, wr, clr, en, ov;
    logic [1:0] xa;
    logic [3:0] wa;
    logic [0:0] sel;

    // Large instance for the random run
    logic       reset2, iv2, ordy2;
    logic       ir2, wr2, clr2, en2, ov2;
    logic [2:0] xa2;
    logic [4:0] wa2;
    logic [1:0] sel2;

`ifdef MVM_LAYER_CTRL_PERF_EN
    logic [31:0] bc, sc, bc2, sc2;
`endif

    mvm_layer_ctrl dut (
        .clk(clk), .reset(reset), .input_valid(iv), .input_ready(ir),
        .x_wr_en(wr), .x_addr(xa), .w_addr(wa), .mac_clear(clr), .mac_en(en),
        .out_sel(sel), .output_valid(ov), .output_ready(ordy)
`ifdef MVM_LAYER_CTRL_PERF_EN
        , .busy_cycles(bc), .stall_cycles(sc)
`endif
    );

    mvm_layer_ctrl #(.M(16), .N(8), .P(4)) dut2 (
        .clk(clk), .reset(reset2), .input_valid(iv2), .input_ready(ir2),
        .x_wr_en(wr2), .x_addr(xa2), .w_addr(wa2), .mac_clear(clr2), .mac_en(en2),
        .out_sel(sel2), .output_valid(ov2), .output_ready(ordy2)
`ifdef MVM_LAYER_CTRL_PERF_EN
        , .busy_cycles(bc2), .stall_cycles(sc2)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dc(input string nm, input int act, input int exp);
        if (exp >= 0) chk(nm, act, exp);
    endtask

    typedef struct {
        int cyc;
        bit iv;
        bit ordy;
        int ir, wr, xa, wa, clr, en, ov, sel;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input int c, input int r, input int w, input int x, input int a,
                           input int cl, input int e, input int o, input int s);
        vec_t v;
        v.cyc = c; v.iv = 1'b1; v.ordy = 1'b1;
        v.ir = r; v.wr = w; v.xa = x; v.wa = a; v.clr = cl; v.en = e; v.ov = o; v.sel = s;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1; iv = 1'b0; ordy = 1'b0;
        @(negedge clk);
        chk("rst_ir", int'(ir), 0);
        chk("rst_ov", int'(ov), 0);
        chk("rst_clr", int'(clr), 0);
        chk("rst_en", int'(en), 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Random-run scoreboard
    int exp_x[$];
    int exp_w[$];
    int exp_sel[$];
    bit rnd_on = 1'b0;
    int hs = 0;
    int cmp_left = 0;
    int mac_cnt = 0;
    bit armed = 1'b0;

    // Monitor for the large instance: pops expectations as the DUT produces strobes.
    always @(negedge clk) begin
        if (rnd_on) begin
            if (wr2) begin
                if (exp_x.size() == 0) chk("rnd_wr_unexpected", 1, 0);
                else chk("rnd_wr_addr", int'(xa2), exp_x.pop_front());
            end
            if (clr2) begin
                cmp_left = 8;
                mac_cnt  = 0;
                armed    = 1'b1;
            end
            if (cmp_left > 0) begin
                if (exp_w.size() == 0) chk("rnd_w_unexpected", 1, 0);
                else begin
                    int w;
                    w = exp_w.pop_front();
                    chk("rnd_w_addr", int'(wa2), w);
                    chk("rnd_x_rd_addr", int'(xa2), w % 8);
                end
                cmp_left--;
            end
            if (en2) mac_cnt++;
            if (ov2 && armed) begin
                chk("rnd_mac_en_count", mac_cnt, 8);
                armed = 1'b0;
            end
            if (ov2 && ordy2) begin
                if (exp_sel.size() == 0) chk("rnd_hs_unexpected", 1, 0);
                else chk("rnd_out_sel", int'(sel2), exp_sel.pop_front());
                hs++;
            end
        end
    end

    initial begin
        bit gap_pat [0:6];
        int cnt;
        int cyc;
        int ldc;
        int vec_loaded;

        reset2 = 1'b1; iv2 = 1'b0; ordy2 = 1'b0;
        gap_pat[0] = 1; gap_pat[1] = 0; gap_pat[2] = 0; gap_pat[3] = 1;
        gap_pat[4] = 1; gap_pat[5] = 0; gap_pat[6] = 1;

        //        c  ir wr xa  wa clr en ov sel
        add_row( 0, 1, 1, 0, -1, 0, 0, 0, -1);
        add_row( 1, 1, 1, 1, -1, 0, 0, 0, -1);
        add_row( 2, 1, 1, 2, -1, 0, 0, 0, -1);
        add_row( 3, 1, 1, 3, -1, 0, 0, 0, -1);
        add_row( 4, 0, 0, 0,  0, 1, 0, 0, -1);
        add_row( 5, 0, 0, 1,  1, 0, 1, 0, -1);
        add_row( 6, 0, 0, 2,  2, 0, 1, 0, -1);
        add_row( 7, 0, 0, 3,  3, 0, 1, 0, -1);
        add_row( 8, 0, 0, -1, -1, 0, 1, 0, -1);
        add_row( 9, 0, 0, -1, -1, 0, 0, 1,  0);
        add_row(10, 0, 0, -1, -1, 0, 0, 1,  1);
        add_row(11, 0, 0, 0,  4, 1, 0, 0, -1);
        add_row(25, 0, 0, 0, 12, 1, 0, 0, -1);
        add_row(26, 0, 0, 1, 13, 0, 1, 0, -1);
        add_row(27, 0, 0, 2, 14, 0, 1, 0, -1);
        add_row(28, 0, 0, 3, 15, 0, 1, 0, -1);
        add_row(29, 0, 0, -1, -1, 0, 1, 0, -1);
        add_row(30, 0, 0, -1, -1, 0, 0, 1,  0);
        add_row(31, 0, 0, -1, -1, 0, 0, 1,  1);
        add_row(32, 1, 1, 0, -1, 0, 0, 0, -1);

        // Full-rate vector, table-driven
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            iv = 1'b1; ordy = 1'b1;
            foreach (tbl[i]) if (tbl[i].cyc == c) begin iv = tbl[i].iv; ordy = tbl[i].ordy; end
            @(negedge clk);
            foreach (tbl[i]) begin
                if (tbl[i].cyc == c) begin
                    chk("fr_input_ready", int'(ir), tbl[i].ir);
                    chk("fr_x_wr_en", int'(wr), tbl[i].wr);
                    chk_dc("fr_x_addr", int'(xa), tbl[i].xa);
                    chk_dc("fr_w_addr", int'(wa), tbl[i].wa);
                    chk("fr_mac_clear", int'(clr), tbl[i].clr);
                    chk("fr_mac_en", int'(en), tbl[i].en);
                    chk("fr_output_valid", int'(ov), tbl[i].ov);
                    chk_dc("fr_out_sel", int'(sel), tbl[i].sel);
                end
            end
`ifdef MVM_LAYER_CTRL_PERF_EN
            if (c == 32) begin
                chk("perf_busy_full_rate", int'(bc), 28);
                chk("perf_stall_full_rate", int'(sc), 0);
            end
`endif
            @(posedge clk); #1;
        end

        // Input gaps
        do_reset();
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            iv = gap_pat[i]; ordy = 1'b1;
            @(negedge clk);
            chk("gap_input_ready", int'(ir), 1);
            chk("gap_x_wr_en", int'(wr), int'(gap_pat[i]));
            if (gap_pat[i]) begin
                chk("gap_x_addr", int'(xa), cnt);
                cnt++;
            end
            @(posedge clk); #1;
        end
        iv = 1'b0;
        @(negedge clk);
        chk("gap_compute_start", int'(clr), 1);
        chk("gap_ready_low", int'(ir), 0);
        @(posedge clk); #1;

        // Back-pressure in pass 1 EMIT
        do_reset();
        for (int c = 0; c <= 23; c++) begin
            iv = (c < 4);
            ordy = !(c >= 16 && c <= 20);
            @(negedge clk);
            if (c >= 16 && c <= 20) begin
                chk("bp_output_valid", int'(ov), 1);
                chk("bp_out_sel", int'(sel), 0);
                chk("bp_no_compute", int'(clr), 0);
            end
            if (c == 21) begin
                chk("bp_hs0_valid", int'(ov), 1);
                chk("bp_hs0_sel", int'(sel), 0);
            end
            if (c == 22) chk("bp_hs1_sel", int'(sel), 1);
            if (c == 23) begin
                chk("bp_pass2_clear", int'(clr), 1);
                chk("bp_pass2_w_addr", int'(wa), 8);
`ifdef MVM_LAYER_CTRL_PERF_EN
                chk("perf_stall_bp", int'(sc), 5);
`endif
            end
            @(posedge clk); #1;
        end

        // Reset during pass 2 EMIT with e=1
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            iv = (c < 4); ordy = 1'b1;
            if (c == 24) reset = 1'b1;
            @(negedge clk);
            if (c == 23) chk("mr_pre_sel0", int'(sel), 0);
            if (c == 24) chk("mr_reset_cycle_ov", int'(ov), 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; iv = 1'b0;
        @(negedge clk);
        chk("mr_after_ov", int'(ov), 0);
        chk("mr_after_ir", int'(ir), 1);
        chk("mr_after_en", int'(en), 0);
        chk("mr_after_clr", int'(clr), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1;
            @(negedge clk);
            chk("mr_reload_wr", int'(wr), 1);
            chk("mr_reload_addr", int'(xa), i);
            @(posedge clk); #1;
        end
        iv = 1'b0;
        @(negedge clk);
        chk("mr_next_clear", int'(clr), 1);
        chk("mr_next_w_addr", int'(wa), 0);
        @(posedge clk); #1;

        // Randomized valid/ready on the large instance
        reset2 = 1'b0;
        @(posedge clk); #1;
        rnd_on = 1'b1;
        cyc = 0; ldc = 0; vec_loaded = 0;
        while (hs < 1600 && cyc < 40000) begin
            iv2   = (vec_loaded < 100) && ($urandom_range(0, 3) != 0);
            ordy2 = ($urandom_range(0, 2) != 0);
            if (iv2 && ir2) begin
                exp_x.push_back(ldc);
                ldc++;
                if (ldc == 8) begin
                    ldc = 0;
                    vec_loaded++;
                    for (int p = 0; p < 4; p++) begin
                        for (int k = 0; k < 8; k++) exp_w.push_back(p * 8 + k);
                        for (int e = 0; e < 4; e++) exp_sel.push_back(e);
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        rnd_on = 1'b0;
        iv2 = 1'b0; ordy2 = 1'b0;
        chk("rnd_handshakes", hs, 1600);
        chk("rnd_w_left", exp_w.size(), 0);
        chk("rnd_sel_left", exp_sel.size(), 0);
        chk("rnd_x_left", exp_x.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mvm_layer_ctrl.md
Name: mvm_layer_ctrl

Overview:
- Control sequencer for one fully connected layer of the net_* pipeline (matrix-vector multiply, ReLU, T-bit fixed point).
- Drives the layer's input-vector memory, weight ROM addresses and P parallel MAC units.
- Sequences load, compute and emit phases with valid/ready handshakes on both sides.
- Contains no arithmetic; output_data is muxed by the datapath from out_sel.

Parameters:
- M, 8: output vector length (neurons); M % P == 0.
- N, 4: input vector length; N >= 2.
- P, 2: parallel MAC units; P >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- input_valid  in  1  upstream word valid.
- input_ready  out  1  block accepts an input word.
- x_wr_en  out  1  write strobe for input-vector memory.
- x_addr  out  $clog2(N)  input-vector memory address, used for both write and read.
- w_addr  out  $clog2(M/P*N)  shared address to the P weight ROMs.
- mac_clear  out  1  zero all P accumulators at this edge.
- mac_en  out  1  accumulate product into all P accumulators at this edge.
- out_sel  out  $clog2(P)  accumulator selected onto output_data.
- output_valid  out  1  downstream word valid.
- output_ready  in  1  downstream accepts a word.

Behaviour:
- Memory read latency is 1 cycle; the MAC sums at the edge where mac_en=1.
- State machine: LOAD, COMPUTE, DRAIN, EMIT. Counters: ld (0..N-1), k (0..N-1), pass (0..M/P-1), e (0..P-1).
- Reset values: state LOAD; all counters 0; all outputs 0 during the reset cycle.
- LOAD:
  - input_ready=1.
  - x_wr_en = input_valid & input_ready, combinationally; x_addr = ld.
  - Each accepted word increments ld. The word where ld==N-1 moves to COMPUTE with k=0.
  - Cycles with input_valid=0 stall without effect.
- COMPUTE (exactly N cycles):
  - x_addr = k; w_addr = pass*N + k; k increments each cycle.
  - mac_clear=1 only in the first cycle (k==0).
  - mac_en=1 in cycles 2..N of COMPUTE and in the DRAIN cycle, i.e. mac_en is the issue flag delayed by one cycle.
  - After k==N-1 go to DRAIN.
- DRAIN (1 cycle): mac_en=1 for the last product; go to EMIT with e=0.
- EMIT:
  - output_valid=1; out_sel=e, held stable while output_ready=0.
  - Each output_valid & output_ready increments e.
  - The handshake with e==P-1 goes to LOAD (and clears pass) if pass==M/P-1; otherwise it increments pass and goes to COMPUTE.
- input_ready=0 outside LOAD. output_valid=0 outside EMIT. mac_clear, mac_en and x_wr_en are 0 in all other cases.
- Minimum latency per vector: N + (M/P)*(N+1+P) cycles. Default parameters: 4 + 4*7 = 32.
- Reset mid-operation:
  - Any state is abandoned; the next cycle is LOAD with ld=0.
  - A partially loaded vector or partially emitted outputs are discarded.
  - No output strobe is asserted in the cycle after reset.
- Counter wrap: all counters return to 0 on phase exit. Addresses never exceed N-1 or M/P*N-1.

Optional Feature:
- Macro: MVM_LAYER_CTRL_PERF_EN.
- When defined, adds two ports: busy_cycles (out, 32 bits) and stall_cycles (out, 32 bits).
  - busy_cycles increments every cycle the state is not LOAD.
  - stall_cycles increments every EMIT cycle with output_ready=0.
  - Both saturate at 2^32-1 and are cleared by reset.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Full rate, defaults, input_valid and output_ready held 1:
  - 4 loads on x_addr 0..3.
  - Pass 0: mac_clear in COMPUTE cycle 1, w_addr 0,1,2,3, mac_en for 4 cycles, out_sel 0 then 1.
  - Pass 3 uses w_addr 12..15.
  - input_ready returns high exactly 32 cycles after the first accepted word.
- Input gaps, input_valid = 1,0,0,1,1,0,1: x_wr_en only on the 4 valid cycles, addresses 0..3; COMPUTE starts the cycle after the 4th accept.
- Back-pressure, output_ready low 5 cycles in EMIT of pass 1: output_valid stays 1, out_sel stays 0, pass does not advance; the first handshake occurs when output_ready rises.
- Reset asserted during pass 2 EMIT with e=1: next cycle output_valid=0, input_ready=1, ld=0; the next vector produces w_addr starting at 0.
- Randomized valid/ready over 100 vectors with P=4, M=16, N=8:
  - Exactly 16 output handshakes per vector.
  - Each w_addr sequence is 0..31 in 8-long runs.
  - mac_en count = 8 per pass.
- With MVM_LAYER_CTRL_PERF_EN defined, the first full-rate vector gives busy_cycles=28 and stall_cycles=0; the back-pressure case adds stall_cycles=5.
